// File: rtl/enemy_wave_control.sv
// enemy_wave_control
//   Multi-slot enemy controller. Each slot is one enemy that flies leftward
//   along its own fixed lane. The block allocates free slots on spawn
//   requests and moves every flying enemy on a shared speed tick. An enemy
//   is retired when it is killed or when it reaches the base line. Per-slot
//   coordinates are reported to the vector renderer.
//
// Build option:
//   ENEMY_EXPLODE_EN - when defined, a killed enemy holds its position in an
//                      EXPLODE state for EXPLODE_TICKS speed pulses before
//                      the slot is freed. When undefined, a kill frees the
//                      slot at once and exploding is tied low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                block enable; low clears every slot like reset
//   speed_pulse       single-cycle movement tick
//   spawn_pulse       single-cycle spawn request
//   kill_valid/idx    kill request for one slot
//   xenemy/yenemy     packed per-slot coordinates, slot i at [i*OUT_WIDTH +: OUT_WIDTH]
//   active/exploding  per-slot FLY / EXPLODE flags
//   base_hit          per-slot one-cycle pulse when an enemy reaches the base
//   spawn_drop        one-cycle pulse when a spawn found no free slot
//   alive_count       number of FLY slots
//
// Slot states:
//   state     | meaning
//   S_IDLE    | slot free, x=y=0
//   S_FLY     | enemy moving toward the base
//   S_EXPLODE | enemy killed, position frozen while the countdown runs

module enemy_wave_control #(
  parameter int OUT_WIDTH     = 8,
  parameter int N_ENEMIES     = 4,
  parameter int X_START       = 255,
  parameter int X_LIMIT       = 16,
  parameter int SPEED_STEP    = 1,
  parameter int Y_BASE        = 40,
  parameter int Y_STEP        = 32,
  parameter int EXPLODE_TICKS = 4,
  localparam int IDX_W = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1,
  localparam int CNT_W = $clog2(N_ENEMIES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           speed_pulse,
  input  logic                           spawn_pulse,
  input  logic                           kill_valid,
  input  logic [IDX_W-1:0]               kill_idx,
  output logic [N_ENEMIES*OUT_WIDTH-1:0] xenemy,
  output logic [N_ENEMIES*OUT_WIDTH-1:0] yenemy,
  output logic [N_ENEMIES-1:0]           active,
  output logic [N_ENEMIES-1:0]           exploding,
  output logic [N_ENEMIES-1:0]           base_hit,
  output logic                           spawn_drop,
  output logic [CNT_W-1:0]               alive_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLY     = 2'd1,
    S_EXPLODE = 2'd2
  } slot_state_t;

  localparam logic [OUT_WIDTH-1:0] X_LOAD = OUT_WIDTH'(X_START);
  localparam logic [OUT_WIDTH-1:0] STEP_V = OUT_WIDTH'(SPEED_STEP);
  // One extra bit so X_LIMIT+SPEED_STEP cannot wrap when compared with x.
  localparam logic [OUT_WIDTH:0]   BASE_THRESH = (OUT_WIDTH+1)'(X_LIMIT + SPEED_STEP);

  slot_state_t                state_q [N_ENEMIES];
  slot_state_t                state_d [N_ENEMIES];
  logic [OUT_WIDTH-1:0]       x_q     [N_ENEMIES];
  logic [OUT_WIDTH-1:0]       x_d     [N_ENEMIES];
  logic [OUT_WIDTH-1:0]       y_q     [N_ENEMIES];
  logic [OUT_WIDTH-1:0]       y_d     [N_ENEMIES];
  logic [N_ENEMIES-1:0]       active_q, active_d;
  logic [N_ENEMIES-1:0]       base_hit_q, base_hit_d;
  logic                       spawn_drop_q, spawn_drop_d;
  logic [CNT_W-1:0]           alive_count_q, alive_count_d;

  logic [N_ENEMIES-1:0]       spawn_sel;
  logic                       spawn_found;
  logic [N_ENEMIES-1:0]       kill_hit;

`ifdef ENEMY_EXPLODE_EN
  localparam int TMR_W = $clog2(EXPLODE_TICKS + 1);
  logic [TMR_W-1:0]           tmr_q   [N_ENEMIES];
  logic [TMR_W-1:0]           tmr_d   [N_ENEMIES];
  logic [N_ENEMIES-1:0]       exploding_q, exploding_d;
`else
  logic                       unused_cfg;
  assign unused_cfg = (EXPLODE_TICKS != 0);
`endif

  // Lowest-index free slot, judged on the registered state only, so a slot
  // freed this cycle becomes spawnable next cycle.
  always_comb begin
    spawn_found = 1'b0;
    spawn_sel   = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (!spawn_found && state_q[i] == S_IDLE) begin
        spawn_sel[i] = 1'b1;
        spawn_found  = 1'b1;
      end
    end
  end

  // Out-of-range kill_idx never matches a slot and is therefore ignored.
  always_comb begin
    kill_hit = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      kill_hit[i] = kill_valid && (32'(kill_idx) == i);
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    base_hit_d = '0;
`ifdef ENEMY_EXPLODE_EN
    tmr_d      = tmr_q;
`endif
    for (int i = 0; i < N_ENEMIES; i++) begin
      case (state_q[i])
        S_IDLE: begin
          if (spawn_pulse && spawn_sel[i]) begin
            state_d[i] = S_FLY;
            x_d[i]     = X_LOAD;
            y_d[i]     = OUT_WIDTH'(Y_BASE + i * Y_STEP);
          end
        end
        S_FLY: begin
          // A kill outranks reaching the base in the same cycle.
          if (kill_hit[i]) begin
`ifdef ENEMY_EXPLODE_EN
            state_d[i] = S_EXPLODE;
            tmr_d[i]   = TMR_W'(EXPLODE_TICKS);
`else
            state_d[i] = S_IDLE;
            x_d[i]     = '0;
            y_d[i]     = '0;
`endif
          end else if (speed_pulse) begin
            if ({1'b0, x_q[i]} <= BASE_THRESH) begin
              state_d[i]    = S_IDLE;
              x_d[i]        = '0;
              y_d[i]        = '0;
              base_hit_d[i] = 1'b1;
            end else begin
              x_d[i] = x_q[i] - STEP_V;
            end
          end
        end
        S_EXPLODE: begin
`ifdef ENEMY_EXPLODE_EN
          if (speed_pulse) begin
            if (tmr_q[i] <= TMR_W'(1)) begin
              state_d[i] = S_IDLE;
              x_d[i]     = '0;
              y_d[i]     = '0;
              tmr_d[i]   = '0;
            end else begin
              tmr_d[i] = tmr_q[i] - TMR_W'(1);
            end
          end
`else
          state_d[i] = S_IDLE;
          x_d[i]     = '0;
          y_d[i]     = '0;
`endif
        end
        default: begin
          state_d[i] = S_IDLE;
          x_d[i]     = '0;
          y_d[i]     = '0;
        end
      endcase
    end

    active_d      = '0;
    alive_count_d = '0;
`ifdef ENEMY_EXPLODE_EN
    exploding_d   = '0;
`endif
    for (int i = 0; i < N_ENEMIES; i++) begin
      active_d[i]   = (state_d[i] == S_FLY);
      alive_count_d = alive_count_d + CNT_W'(active_d[i]);
`ifdef ENEMY_EXPLODE_EN
      exploding_d[i] = (state_d[i] == S_EXPLODE);
`endif
    end

    spawn_drop_d = spawn_pulse && !spawn_found;
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      for (int i = 0; i < N_ENEMIES; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
`ifdef ENEMY_EXPLODE_EN
        tmr_q[i]   <= '0;
`endif
      end
      active_q      <= '0;
      base_hit_q    <= '0;
      spawn_drop_q  <= 1'b0;
      alive_count_q <= '0;
`ifdef ENEMY_EXPLODE_EN
      exploding_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      base_hit_q    <= base_hit_d;
      spawn_drop_q  <= spawn_drop_d;
      alive_count_q <= alive_count_d;
`ifdef ENEMY_EXPLODE_EN
      tmr_q         <= tmr_d;
      exploding_q   <= exploding_d;
`endif
    end
  end

  always_comb begin
    xenemy = '0;
    yenemy = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      xenemy[i*OUT_WIDTH +: OUT_WIDTH] = x_q[i];
      yenemy[i*OUT_WIDTH +: OUT_WIDTH] = y_q[i];
    end
  end

  assign active      = active_q;
  assign base_hit    = base_hit_q;
  assign spawn_drop  = spawn_drop_q;
  assign alive_count = alive_count_q;
`ifdef ENEMY_EXPLODE_EN
  assign exploding   = exploding_q;
`else
  assign exploding   = '0;
`endif

endmodule

// File: tb/tb_enemy_wave_control.sv
module tb_enemy_wave_control;

  logic        clk;
  logic        rst;
  logic        en;
  logic        speed_pulse;
  logic        spawn_pulse;
  logic        kill_valid;
  logic [1:0]  kill_idx;
  logic [31:0] xenemy;
  logic [31:0] yenemy;
  logic [3:0]  active;
  logic [3:0]  exploding;
  logic [3:0]  base_hit;
  logic        spawn_drop;
  logic [2:0]  alive_count;

  int n_checks = 0;
  int n_fail   = 0;

  enemy_wave_control dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .speed_pulse (speed_pulse),
    .spawn_pulse (spawn_pulse),
    .kill_valid  (kill_valid),
    .kill_idx    (kill_idx),
    .xenemy      (xenemy),
    .yenemy      (yenemy),
    .active      (active),
    .exploding   (exploding),
    .base_hit    (base_hit),
    .spawn_drop  (spawn_drop),
    .alive_count (alive_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic spawn();
    spawn_pulse = 1'b1;
    tick();
    spawn_pulse = 1'b0;
  endtask

  task automatic speed(input int n);
    for (int k = 0; k < n; k++) begin
      speed_pulse = 1'b1;
      tick();
      speed_pulse = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (xenemy !== 32'h0) begin
      n_fail++; $display("FAIL reset_x got %h want 0", xenemy);
    end
    n_checks++;
    if (yenemy !== 32'h0) begin
      n_fail++; $display("FAIL reset_y got %h want 0", yenemy);
    end
    n_checks++;
    if ({active, exploding, base_hit, spawn_drop, alive_count} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_flags got act=%b exp=%b bh=%b drop=%b cnt=%0d want all 0",
               active, exploding, base_hit, spawn_drop, alive_count);
    end
  endtask

  task automatic test_spawn_fill();
    do_reset();
    for (int i = 0; i < 4; i++) spawn();
    n_checks++;
    if (active !== 4'hF) begin
      n_fail++; $display("FAIL fill_active got %b want 1111", active);
    end
    n_checks++;
    if (xenemy !== {4{8'd255}}) begin
      n_fail++; $display("FAIL fill_x got %h want ffffffff", xenemy);
    end
    n_checks++;
    if (yenemy !== {8'd136, 8'd104, 8'd72, 8'd40}) begin
      n_fail++; $display("FAIL fill_y got %h want 88684828", yenemy);
    end
    n_checks++;
    if (spawn_drop !== 1'b0) begin
      n_fail++; $display("FAIL fill_nodrop got %b want 0", spawn_drop);
    end
    spawn();
    n_checks++;
    if (spawn_drop !== 1'b1) begin
      n_fail++; $display("FAIL fill_drop got %b want 1", spawn_drop);
    end
    n_checks++;
    if (alive_count !== 3'd4) begin
      n_fail++; $display("FAIL fill_count got %0d want 4", alive_count);
    end
    tick();
    n_checks++;
    if (spawn_drop !== 1'b0) begin
      n_fail++; $display("FAIL fill_drop_pulse got %b want 0", spawn_drop);
    end
  endtask

  task automatic test_move_base();
    do_reset();
    spawn();
    speed(3);
    n_checks++;
    if (xenemy[7:0] !== 8'd252) begin
      n_fail++; $display("FAIL move_x3 got %0d want 252", xenemy[7:0]);
    end
    speed(235);
    n_checks++;
    if (xenemy[7:0] !== 8'd17 || active !== 4'b0001 || base_hit !== 4'b0) begin
      n_fail++;
      $display("FAIL move_x17 got x=%0d act=%b bh=%b want x=17 act=0001 bh=0000",
               xenemy[7:0], active, base_hit);
    end
    speed(1);
    n_checks++;
    if (base_hit !== 4'b0001) begin
      n_fail++; $display("FAIL base_hit got %b want 0001", base_hit);
    end
    n_checks++;
    if (active !== 4'b0 || xenemy !== 32'h0 || yenemy !== 32'h0 || alive_count !== 3'd0) begin
      n_fail++;
      $display("FAIL base_idle got act=%b x=%h y=%h cnt=%0d want 0", active, xenemy, yenemy, alive_count);
    end
    tick();
    n_checks++;
    if (base_hit !== 4'b0) begin
      n_fail++; $display("FAIL base_hit_pulse got %b want 0000", base_hit);
    end
  endtask

  task automatic test_kill();
    do_reset();
    spawn();
    spawn();
    speed(55);
    n_checks++;
    if (xenemy[15:0] !== {8'd200, 8'd200}) begin
      n_fail++; $display("FAIL kill_pre_x got %h want c8c8", xenemy[15:0]);
    end
    // Kill on an idle slot is ignored.
    kill_valid = 1'b1; kill_idx = 2'd3;
    tick();
    kill_valid = 1'b0;
    n_checks++;
    if (active !== 4'b0011 || exploding !== 4'b0) begin
      n_fail++; $display("FAIL kill_idle got act=%b exp=%b want 0011 0000", active, exploding);
    end
    kill_valid = 1'b1; kill_idx = 2'd1;
    tick();
    kill_valid = 1'b0;
`ifdef ENEMY_EXPLODE_EN
    n_checks++;
    if (active !== 4'b0001 || exploding !== 4'b0010 || xenemy[15:8] !== 8'd200) begin
      n_fail++;
      $display("FAIL kill_explode got act=%b exp=%b x1=%0d want 0001 0010 200",
               active, exploding, xenemy[15:8]);
    end
    speed(3);
    n_checks++;
    if (exploding !== 4'b0010 || xenemy[15:8] !== 8'd200 || yenemy[15:8] !== 8'd72) begin
      n_fail++;
      $display("FAIL kill_hold got exp=%b x1=%0d y1=%0d want 0010 200 72",
               exploding, xenemy[15:8], yenemy[15:8]);
    end
    speed(1);
    n_checks++;
    if (exploding !== 4'b0 || xenemy[15:8] !== 8'd0 || yenemy[15:8] !== 8'd0) begin
      n_fail++;
      $display("FAIL kill_done got exp=%b x1=%0d y1=%0d want 0 0 0", exploding, xenemy[15:8], yenemy[15:8]);
    end
`else
    n_checks++;
    if (active !== 4'b0001 || exploding !== 4'b0 || xenemy[15:8] !== 8'd0 || yenemy[15:8] !== 8'd0) begin
      n_fail++;
      $display("FAIL kill_direct got act=%b exp=%b x1=%0d y1=%0d want 0001 0000 0 0",
               active, exploding, xenemy[15:8], yenemy[15:8]);
    end
`endif
    n_checks++;
    if (alive_count !== 3'd1) begin
      n_fail++; $display("FAIL kill_count got %0d want 1", alive_count);
    end
  endtask

  task automatic test_kill_vs_base();
    do_reset();
    spawn();
    speed(238);
    kill_valid = 1'b1; kill_idx = 2'd0; speed_pulse = 1'b1;
    tick();
    kill_valid = 1'b0; speed_pulse = 1'b0;
    n_checks++;
    if (base_hit !== 4'b0) begin
      n_fail++; $display("FAIL kvb_base_hit got %b want 0000", base_hit);
    end
`ifdef ENEMY_EXPLODE_EN
    n_checks++;
    if (exploding !== 4'b0001 || xenemy[7:0] !== 8'd17) begin
      n_fail++; $display("FAIL kvb_state got exp=%b x=%0d want 0001 17", exploding, xenemy[7:0]);
    end
`else
    n_checks++;
    if (active !== 4'b0 || xenemy[7:0] !== 8'd0) begin
      n_fail++; $display("FAIL kvb_state got act=%b x=%0d want 0000 0", active, xenemy[7:0]);
    end
`endif
  endtask

  task automatic test_kill_spawn_same();
    do_reset();
    for (int i = 0; i < 4; i++) spawn();
    speed(5);
    kill_valid = 1'b1; kill_idx = 2'd2; spawn_pulse = 1'b1;
    tick();
    kill_valid = 1'b0; spawn_pulse = 1'b0;
    n_checks++;
    if (spawn_drop !== 1'b1 || active !== 4'b1011) begin
      n_fail++; $display("FAIL kss_drop got drop=%b act=%b want 1 1011", spawn_drop, active);
    end
    spawn();
`ifdef ENEMY_EXPLODE_EN
    n_checks++;
    if (spawn_drop !== 1'b1 || exploding !== 4'b0100) begin
      n_fail++; $display("FAIL kss_respawn got drop=%b exp=%b want 1 0100", spawn_drop, exploding);
    end
`else
    n_checks++;
    if (active !== 4'hF || spawn_drop !== 1'b0 || xenemy !== {8'd250, 8'd255, 8'd250, 8'd250}) begin
      n_fail++;
      $display("FAIL kss_respawn got act=%b drop=%b x=%h want 1111 0 faff fafa", active, spawn_drop, xenemy);
    end
    n_checks++;
    if (yenemy[23:16] !== 8'd104) begin
      n_fail++; $display("FAIL kss_y2 got %0d want 104", yenemy[23:16]);
    end
`endif
  endtask

  task automatic test_enable();
    do_reset();
    spawn();
    spawn();
    speed(10);
    en = 1'b0;
    tick();
    en = 1'b1;
    n_checks++;
    if (xenemy !== 32'h0 || yenemy !== 32'h0 || active !== 4'b0 || alive_count !== 3'd0) begin
      n_fail++;
      $display("FAIL en_clear got x=%h y=%h act=%b cnt=%0d want 0", xenemy, yenemy, active, alive_count);
    end
    spawn();
    n_checks++;
    if (active !== 4'b0001 || xenemy[7:0] !== 8'd255 || yenemy[7:0] !== 8'd40 || alive_count !== 3'd1) begin
      n_fail++;
      $display("FAIL en_respawn got act=%b x0=%0d y0=%0d cnt=%0d want 0001 255 40 1",
               active, xenemy[7:0], yenemy[7:0], alive_count);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; speed_pulse = 1'b0; spawn_pulse = 1'b0;
    kill_valid = 1'b0; kill_idx = 2'd0;
    tick();
    test_reset();
    test_spawn_fill();
    test_move_base();
    test_kill();
    test_kill_vs_base();
    test_kill_spawn_same();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_wave_control.md
# enemy_wave_control

Multi-slot enemy controller that manages up to N_ENEMIES concurrent enemies, each flying leftward along its own fixed lane toward a base. It allocates free slots on spawn requests, advances every flying enemy on a shared speed tick, retires enemies on a kill or on reaching the base line, and reports per-slot coordinates to the vector renderer. It sits between the game timing/pulse generators and the vector drawing pipeline, alongside the player and missile controllers.

## Interface
- OUT_WIDTH, 8: coordinate width in bits.
- N_ENEMIES, 4: number of enemy slots (1..16).
- X_START, 255: x loaded into a slot on spawn.
- X_LIMIT, 16: base line; an enemy reaching it scores a base hit.
- SPEED_STEP, 1: x decrement per speed_pulse (1..X_START-X_LIMIT).
- Y_BASE, 40: lane y of slot 0.
- Y_STEP, 32: lane spacing; slot i has y = Y_BASE + i*Y_STEP (truncated to OUT_WIDTH).
- EXPLODE_TICKS, 4: speed pulses an explosion is held (≥1).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  block enable; low acts as reset of all slots.
- speed_pulse  in  1  single-cycle movement tick.
- spawn_pulse  in  1  single-cycle spawn request.
- kill_valid  in  1  kill request qualifier.
- kill_idx  in  $clog2(N_ENEMIES) (min 1)  slot to kill.
- xenemy  out  N_ENEMIES*OUT_WIDTH  packed x per slot, slot i at [i*OUT_WIDTH +: OUT_WIDTH].
- yenemy  out  N_ENEMIES*OUT_WIDTH  packed y per slot, same layout.
- active  out  N_ENEMIES  slot is FLY.
- exploding  out  N_ENEMIES  slot is EXPLODE.
- base_hit  out  N_ENEMIES  one-cycle pulse: slot reached base.
- spawn_drop  out  1  one-cycle pulse: spawn request found no free slot.
- alive_count  out  $clog2(N_ENEMIES+1)  number of FLY slots.

## Operation
- Per-slot FSM: IDLE → FLY (spawn), FLY → EXPLODE (kill), FLY → IDLE (base reached), EXPLODE → IDLE (countdown done).
- Spawn: on spawn_pulse, lowest-index IDLE slot (per registered state) → FLY, x=X_START, y=lane y. No IDLE slot → spawn_drop=1, no state change. One spawn per pulse.
- Move: on speed_pulse each FLY slot not killed this cycle: if x ≤ X_LIMIT+SPEED_STEP (compared at OUT_WIDTH+1 bits) → IDLE, x=0, y=0, base_hit[i]=1; else x -= SPEED_STEP.
- Kill: kill_valid with kill_idx on a FLY slot → EXPLODE, x/y frozen, countdown=EXPLODE_TICKS. Kill on IDLE/EXPLODE slot or kill_idx ≥ N_ENEMIES ignored.
- EXPLODE: countdown decrements on speed_pulse; at 1→0 slot → IDLE, x=y=0.
- Priority per slot: rst/!en > kill > base reach/move. Kill beats base reach in same cycle (no base_hit).
- IDLE slots drive x=y=0. alive_count = popcount of next active, registered.

## Timing
- All outputs registered; state change visible one cycle after the triggering input.
- Reset / !en: all slots IDLE, xenemy=yenemy=0, active=exploding=base_hit=0, spawn_drop=0, alive_count=0, countdowns 0.
- base_hit and spawn_drop high exactly one cycle per event.
- Slot freed in cycle t is spawnable from cycle t+1; a slot spawned in cycle t is not moved by a speed_pulse in cycle t.
- spawn_pulse, speed_pulse and kill on different slots in the same cycle all take effect.

## Configuration
- ENEMY_EXPLODE_EN defined: EXPLODE state and exploding output behave as above.
- Undefined: kill sends FLY → IDLE directly (x=y=0 next cycle); exploding tied to 0; EXPLODE_TICKS unused.

## Test plan
- Reset then 5 spawn_pulses with N_ENEMIES=4 → slots 0..3 active with x=255, y=40,72,104,136; 5th pulse → spawn_drop=1, alive_count=4.
- One slot, 3 speed_pulses → x=252; continue until x=17 then one more pulse → slot IDLE, base_hit[0]=1 for one cycle, x=0.
- Kill slot 1 at x=200 (macro on) → exploding[1]=1, x held 200 for 4 speed pulses, then IDLE; with macro off → IDLE next cycle.
- Kill and base reach on slot 0 in same cycle → EXPLODE, base_hit[0] stays 0.
- All slots full, kill slot 2 (macro off) and spawn_pulse same cycle → spawn_drop=1; spawn next cycle → slot 2 reloaded at x=255.
- en low mid-flight for one cycle → all outputs 0, alive_count=0; en high, spawn → slot 0 used.
